// File: rtl/wb_stage_if.sv
// Bundled MEM->WB inputs, pipeline control, and register-file/forwarding/instret outputs.
// The slave modport is the stage's view; the master modport is the driver's view.
interface wb_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
);
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_opr_res;
  logic [DATA_WIDTH-1:0] mem_lsu_rdata;
  logic [DATA_WIDTH-1:0] mem_pc_plus4;
  logic [4:0]            mem_rd;
  logic                  mem_rf_en;
  logic [1:0]            mem_wb_sel;
  logic                  stall;
  logic                  flush;
  logic                  instret_we;
  logic [CNT_WIDTH-1:0]  instret_wdata;

  logic                  rf_wen;
  logic [4:0]            rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  fwd_en;
  logic [4:0]            fwd_rd;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [CNT_WIDTH-1:0]  instret;

  modport slave (
    input  mem_valid, mem_opr_res, mem_lsu_rdata, mem_pc_plus4, mem_rd,
           mem_rf_en, mem_wb_sel, stall, flush, instret_we, instret_wdata,
    output rf_wen, rf_waddr, rf_wdata, fwd_en, fwd_rd, fwd_data, instret
  );

  modport master (
    output mem_valid, mem_opr_res, mem_lsu_rdata, mem_pc_plus4, mem_rd,
           mem_rf_en, mem_wb_sel, stall, flush, instret_we, instret_wdata,
    input  rf_wen, rf_waddr, rf_wdata, fwd_en, fwd_rd, fwd_data, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback data select, register-file write,
// WB->EX forwarding and the retired-instruction counter.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic         clk,
  input  logic         arst_n,
  wb_stage_if.slave    bus
);

  logic                  valid_q, valid_d;
  logic                  fresh_q, fresh_d;
  logic [DATA_WIDTH-1:0] opr_res_q, opr_res_d;
  logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rf_en_q, rf_en_d;
  logic [1:0]            wb_sel_q, wb_sel_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;

  logic                  retire;
  logic                  writes_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  // Flush beats stall; a stall keeps the instruction but marks it already written.
  always_comb begin
    valid_d     = valid_q;
    fresh_d     = fresh_q;
    opr_res_d   = opr_res_q;
    lsu_rdata_d = lsu_rdata_q;
    pc_plus4_d  = pc_plus4_q;
    rd_d        = rd_q;
    rf_en_d     = rf_en_q;
    wb_sel_d    = wb_sel_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      fresh_d = 1'b0;
    end else if (bus.stall) begin
      fresh_d = 1'b0;
    end else begin
      valid_d     = bus.mem_valid;
      fresh_d     = bus.mem_valid;
      opr_res_d   = bus.mem_opr_res;
      lsu_rdata_d = bus.mem_lsu_rdata;
      pc_plus4_d  = bus.mem_pc_plus4;
      rd_d        = bus.mem_rd;
      rf_en_d     = bus.mem_rf_en;
      wb_sel_d    = bus.mem_wb_sel;
    end
  end

  assign retire = valid_q & fresh_q;

  // A CSR write takes precedence over a same-cycle retirement.
  always_comb begin
    instret_d = instret_q;
    if (bus.instret_we) begin
      instret_d = bus.instret_wdata;
    end else if (retire) begin
      instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      valid_q     <= 1'b0;
      fresh_q     <= 1'b0;
      opr_res_q   <= '0;
      lsu_rdata_q <= '0;
      pc_plus4_q  <= '0;
      rd_q        <= '0;
      rf_en_q     <= 1'b0;
      wb_sel_q    <= 2'd0;
      instret_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      fresh_q     <= fresh_d;
      opr_res_q   <= opr_res_d;
      lsu_rdata_q <= lsu_rdata_d;
      pc_plus4_q  <= pc_plus4_d;
      rd_q        <= rd_d;
      rf_en_q     <= rf_en_d;
      wb_sel_q    <= wb_sel_d;
      instret_q   <= instret_d;
    end
  end

  always_comb begin
    case (wb_sel_q)
      2'd0:    wb_data = opr_res_q;
      2'd1:    wb_data = lsu_rdata_q;
      2'd2:    wb_data = pc_plus4_q;
      default: wb_data = '0;
    endcase
  end

  assign writes_rd = valid_q & rf_en_q & (rd_q != 5'd0) & (wb_sel_q != 2'd3);

  assign bus.rf_wen   = writes_rd & fresh_q;
  assign bus.rf_waddr = rd_q;
  assign bus.rf_wdata = wb_data;
  assign bus.fwd_en   = writes_rd;
  assign bus.fwd_rd   = rd_q;
  assign bus.fwd_data = wb_data;
  assign bus.instret  = instret_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage directly downstream of the memory stage. Holds the MEM/WB pipeline register and selects the register-file write data from the ALU/address result, the LSU-formatted load data, or PC+4. It drives the register-file write port and the WB-to-EX forwarding path. It also maintains the 64-bit retired-instruction counter (instret) used by the CSR unit.

Parameters:
DATA_WIDTH, 32, width of datapath, results and load data
CNT_WIDTH, 64, width of retired-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
arst_n  input  1  reset, synchronous, active-low
mem_valid  input  1  memory stage presents a valid instruction
mem_opr_res  input  DATA_WIDTH  ALU/address result from memory stage
mem_lsu_rdata  input  DATA_WIDTH  LSU-formatted load data from memory stage
mem_pc_plus4  input  DATA_WIDTH  PC+4 of the instruction (jal/jalr link)
mem_rd  input  5  destination register index
mem_rf_en  input  1  instruction writes the register file
mem_wb_sel  input  2  writeback select: 0 opr_res, 1 lsu_rdata, 2 pc_plus4, 3 reserved
stall  input  1  hold MEM/WB register contents
flush  input  1  kill MEM/WB register contents
instret_we  input  1  CSR write to instret
instret_wdata  input  CNT_WIDTH  CSR write value
rf_wen  output  1  register-file write enable
rf_waddr  output  5  register-file write index
rf_wdata  output  DATA_WIDTH  register-file write data
fwd_en  output  1  forwarding data valid for rd
fwd_rd  output  5  forwarding destination index
fwd_data  output  DATA_WIDTH  forwarding data (equals rf_wdata)
instret  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (arst_n=0 at an edge): valid_q, fresh_q and all payload registers are 0. instret is 0. All outputs read 0 in the following cycle.
- Register update priority per edge:
  - reset
  - flush: valid_q<=0, fresh_q<=0; payload don't-care
  - stall: payload and valid_q hold; fresh_q<=0
  - otherwise: load all mem_* inputs, valid_q<=mem_valid, fresh_q<=mem_valid
- Flush beats stall when both are asserted.
- Latency: inputs sampled at edge N are written to the register file on edge N+1, so rf_* is visible during the cycle after N.
- Data select (combinational from registers): sel 0 gives opr_res_q, sel 1 gives lsu_rdata_q, sel 2 gives pc_plus4_q, sel 3 gives 0.
- rf_wen = valid_q & fresh_q & rf_en_q & (rd_q!=0) & (wb_sel_q!=3).
  - A held instruction writes exactly once.
  - x0 is never written.
- fwd_en = valid_q & rf_en_q & (rd_q!=0) & (wb_sel_q!=3).
  - fresh_q is not required, so forwarding stays valid while stalled.
- fwd_rd = rd_q; fwd_data = rf_wdata.
- An instruction retires when valid_q & fresh_q, regardless of rf_en; this covers stores and branches.
- instret update per edge:
  - instret_we=1: instret<=instret_wdata; a retirement in the same cycle is dropped.
  - else on retirement: instret<=instret+1, wrapping modulo 2^CNT_WIDTH.
- Reset mid-stall or mid-flush: reset wins, and the register is empty afterwards.
- No combinational path from mem_* inputs to any output.

Test Plan:
- Reset: hold arst_n=0 two cycles with mem_valid=1 → rf_wen=0, fwd_en=0, instret=0; after release, first valid instruction retires with instret=1.
- Select: mem_valid=1, rd=5, rf_en=1, opr_res=0x1234, lsu_rdata=0xDEAD_BEEF, pc_plus4=0x104, sel=0/1/2/3 on consecutive cycles → rf_wdata 0x1234, 0xDEADBEEF, 0x104, then rf_wen=0; instret increments by 4.
- x0 and stores: rd=0 with rf_en=1 gives rf_wen=0 and fwd_en=0 but instret+1; rf_en=0 (store) gives rf_wen=0 and instret+1.
- Stall: load rd=7, data 0xAA, then stall=1 for 3 cycles → rf_wen=1 for exactly one cycle; fwd_en=1, fwd_rd=7, fwd_data=0xAA for all 4 cycles; instret +1 only.
- Flush vs stall: valid instruction in the register, assert stall=1 and flush=1 together → next cycle valid cleared, rf_wen=0, fwd_en=0, no retirement.
- Counter: instret_we=1 with wdata=0xFFFF_FFFF_FFFF_FFFF while a retirement occurs → instret=0xFFFF…FFFF (increment dropped); next retirement → instret=0 (wrap).
